key_debounce_edge: RTL and testbench
====================================

// Module: key_debounce_edge
// PURPOSE
// - Front-end conditioning for a raw mechanical key input (e.g. power/off key).
// - Synchronises the asynchronous pad signal, debounces it, and emits a stable
//   level plus one-cycle rise/fall pulses.
// - Sits directly upstream of the off-mode controllers: key_level drives their
//   already-debounced toggle input; key_rise/key_fall feed the mode FSM.
// PARAMETERS
// - SYNC_STAGES       2          synchroniser flops on key_raw (legal >= 2)
// - DEBOUNCE_COUNT    20'd500000 consecutive cycles of disagreement needed to flip key_level
// - LONG_PRESS_COUNT  32'd3000000 cycles key_level must stay high before long_press fires
// - CNT_WIDTH         32         width of internal counters (MAX_WIDTH in the header)
// PORTS
// - clk         input   1  system clock
// - rst         input   1  asynchronous reset, active-high
// - key_raw     input   1  raw key pad, asynchronous to clk, 1 = pressed
// - key_level   output  1  debounced key level (registered)
// - key_rise    output  1  one-cycle pulse on debounced 0->1
// - key_fall    output  1  one-cycle pulse on debounced 1->0
// - long_press  output  1  one-cycle pulse after sustained press (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst=1, async): sync chain, db_cnt, hold_cnt <= 0; key_level, key_rise,
//   key_fall, long_press <= 0. A press during reset is ignored until release.
// - Synchroniser: key_sync = last flop of a SYNC_STAGES shift register on key_raw.
// - Debounce counter db_cnt (CNT_WIDTH bits):
//   - key_sync == key_level: db_cnt <= 0.
//   - key_sync != key_level and db_cnt < DEBOUNCE_COUNT-1: db_cnt <= db_cnt+1.
//   - key_sync != key_level and db_cnt >= DEBOUNCE_COUNT-1: key_level <= key_sync,
//     db_cnt <= 0, matching key_rise/key_fall <= 1 on that same edge.
//   - Any single cycle of agreement restarts the count (no partial credit).
// - DEBOUNCE_COUNT of 0 behaves as 1 (flip on first disagreeing cycle).
// - Latency: key_raw step settles before edge 0 -> key_level changes at edge
//   SYNC_STAGES + DEBOUNCE_COUNT; key_rise/key_fall high for exactly that cycle.
// - key_rise and key_fall are never high together; pulses are always 1 cycle wide.
// - Glitches shorter than DEBOUNCE_COUNT synchronised cycles produce no output change.
// - db_cnt never exceeds DEBOUNCE_COUNT-1; no wrap-around possible.
// - All outputs registered; no combinational path from key_raw to any output.
// CONFIGURATION
// - Macro: KEY_LONG_PRESS_EN
// - Defined: hold_cnt counts up every cycle key_level == 1, cleared when key_level == 0.
//   long_press <= 1 for one cycle on the edge hold_cnt reaches LONG_PRESS_COUNT-1;
//   hold_cnt then saturates at LONG_PRESS_COUNT, no repeat until key_level falls
//   and a new press is debounced. Release before the threshold -> no pulse.
//   hold_cnt restarts from 0 on the key_rise cycle.
// - Not defined: hold_cnt not built; long_press port remains, tied to 1'b0.
// TESTING
// (params for tests: SYNC_STAGES=2, DEBOUNCE_COUNT=4, LONG_PRESS_COUNT=10)
// - Reset: rst=1 with key_raw=1 for 5 cycles, release -> all outputs 0 during reset;
//   key_level rises at edge 6 after release, key_rise pulses once.
// - Clean press: key_raw 0->1 before edge 0, held -> key_level=1 from edge 6,
//   key_rise=1 only at edge 6, key_fall stays 0.
// - Bounce: key_raw 1 for 3 cycles, 0 for 1, then 1 held -> no flip on the first burst;
//   key_level rises 4 synchronised cycles after the final 0->1.
// - Release: from key_level=1, key_raw 1->0 held -> key_level=0 at edge 6, key_fall 1 cycle.
// - Async reset mid-count: rst pulse with db_cnt=2 -> db_cnt and outputs 0 immediately;
//   full 6-cycle latency required afterwards.
// - KEY_LONG_PRESS_EN: hold 12 cycles past key_rise -> one long_press pulse at the
//   10th key_level=1 cycle; release at 8 cycles -> none; without macro long_press == 0.

Source files
------------

// File: rtl/key_debounce_edge.sv
// Raw key conditioning: synchroniser, debounce counter, registered level and edge pulses.
// Optional long-press detector built when KEY_LONG_PRESS_EN is defined.
module key_debounce_edge #(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned DEBOUNCE_COUNT   = 500000,
  parameter int unsigned LONG_PRESS_COUNT = 3000000,
  parameter int unsigned CNT_WIDTH        = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_rise,
  output logic key_fall,
  output logic long_press
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  // A count of 0 is treated as 1: flip on the first disagreeing cycle.
  localparam logic [CNT_WIDTH-1:0] DB_LAST =
    (DEBOUNCE_COUNT == 0) ? '0 : CNT_WIDTH'(DEBOUNCE_COUNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   key_sync;
  logic [CNT_WIDTH-1:0]   db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign key_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (key_sync != level_q) begin
      if (db_cnt_q >= DB_LAST) begin
        level_d = key_sync;
        rise_d  = key_sync;
        fall_d  = ~key_sync;
      end else begin
        db_cnt_d = db_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], key_raw};
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign key_level = level_q;
  assign key_rise  = rise_q;
  assign key_fall  = fall_q;

`ifdef KEY_LONG_PRESS_EN
  // Counter saturates one past the firing point so the pulse cannot repeat.
  localparam logic [CNT_WIDTH-1:0] LP_SAT =
    (LONG_PRESS_COUNT < 2) ? CNT_WIDTH'(2) : CNT_WIDTH'(LONG_PRESS_COUNT);
  localparam logic [CNT_WIDTH-1:0] LP_FIRE = LP_SAT - CNT_ONE;

  logic [CNT_WIDTH-1:0] hold_q, hold_d;
  logic                 lp_q, lp_d;

  always_comb begin
    hold_d = '0;
    lp_d   = 1'b0;
    if (level_q) begin
      hold_d = (hold_q < LP_SAT) ? hold_q + CNT_ONE : hold_q;
      lp_d   = (hold_q < LP_SAT) && (hold_q + CNT_ONE == LP_FIRE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      lp_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      lp_q   <= lp_d;
    end
  end

  assign long_press = lp_q;
`else
  logic unused_lp_count;
  assign unused_lp_count = ^LONG_PRESS_COUNT;
  assign long_press      = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_edge.sv
// Bench for key_debounce_edge: directed scenarios then random key bouncing,
// all checked against a sample-window reference model.
module tb_key_debounce_edge;
  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int LP   = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_raw = 1'b0;
  logic key_level, key_rise, key_fall, long_press;

  int errors = 0;
  int checks = 0;

  key_debounce_edge #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_COUNT(DB), .LONG_PRESS_COUNT(LP), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .key_raw(key_raw),
    .key_level(key_level), .key_rise(key_rise), .key_fall(key_fall),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples delayed through a queue; the level flips once
  // the last DB synchronised samples all disagree with it.
  bit samp_q[$];
  bit seen_q[$];
  bit m_level, m_rise, m_fall, m_lp;
  int m_run;

  int edge_no, rise_cnt, fall_cnt, lp_cnt, rise_edge, fall_edge, lp_edge;

  function automatic void model_reset();
    samp_q.delete();
    for (int i = 0; i < SYNC; i++) samp_q.push_back(1'b0);
    seen_q.delete();
    m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_lp = 1'b0; m_run = 0;
  endfunction

  function automatic void model_edge(bit raw);
    bit seen, old, flip;
    seen = samp_q.pop_front();
    samp_q.push_back(raw);
    seen_q.push_back(seen);
    if (seen_q.size() > DB) void'(seen_q.pop_front());
    flip = (seen_q.size() == DB);
    foreach (seen_q[i]) if (seen_q[i] == m_level) flip = 1'b0;
    old = m_level;
    m_rise = flip && !old;
    m_fall = flip && old;
    if (flip) begin
      m_level = !old;
      seen_q.delete();
    end
    m_run = old ? m_run + 1 : 0;
    m_lp  = old && (m_run == LP - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mark();
    edge_no = 0; rise_cnt = 0; fall_cnt = 0; lp_cnt = 0;
    rise_edge = -1; fall_edge = -1; lp_edge = -1;
  endtask

  task automatic tick();
    bit exp_lp;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(key_raw);
    #1;
    edge_no++;
`ifdef KEY_LONG_PRESS_EN
    exp_lp = m_lp;
`else
    exp_lp = 1'b0;
`endif
    chk("level", {31'b0, key_level}, {31'b0, m_level});
    chk("rise",  {31'b0, key_rise},  {31'b0, m_rise});
    chk("fall",  {31'b0, key_fall},  {31'b0, m_fall});
    chk("long_press", {31'b0, long_press}, {31'b0, exp_lp});
    chk("rise_fall_excl", {31'b0, key_rise & key_fall}, 32'd0);
    if (key_rise === 1'b1) begin rise_cnt++; rise_edge = edge_no; end
    if (key_fall === 1'b1) begin fall_cnt++; fall_edge = edge_no; end
    if (long_press === 1'b1) begin lp_cnt++; lp_edge = edge_no; end
  endtask

  initial begin
    int len;
    bit val;
    model_reset();
    mark();

    // Press held through reset: ignored until release, then full latency.
    rst = 1'b1; key_raw = 1'b1;
    #1;
    chk("rst_level_async", {31'b0, key_level}, 32'd0);
    repeat (5) tick();
    rst = 1'b0;
    mark();
    repeat (8) tick();
    chk("rst_rise_edge", rise_edge, 32'd6);
    chk("rst_rise_cnt", rise_cnt, 32'd1);

    // Release from level high.
    key_raw = 1'b0;
    mark();
    repeat (8) tick();
    chk("release_fall_edge", fall_edge, 32'd6);
    chk("release_fall_cnt", fall_cnt, 32'd1);
    chk("release_rise_cnt", rise_cnt, 32'd0);

    // Clean press.
    key_raw = 1'b1;
    mark();
    repeat (8) tick();
    chk("press_rise_edge", rise_edge, 32'd6);
    chk("press_level", {31'b0, key_level}, 32'd1);
    chk("press_fall_cnt", fall_cnt, 32'd0);
    key_raw = 1'b0;
    repeat (8) tick();

    // Bounce: 3 high, 1 low, then held high.
    key_raw = 1'b1;
    mark();
    repeat (3) tick();
    key_raw = 1'b0;
    tick();
    key_raw = 1'b1;
    repeat (8) tick();
    chk("bounce_rise_edge", rise_edge, 32'd10);
    chk("bounce_rise_cnt", rise_cnt, 32'd1);

    // Async reset while counting towards a release.
    key_raw = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async_level", {31'b0, key_level}, 32'd0);
    chk("async_rise",  {31'b0, key_rise},  32'd0);
    chk("async_fall",  {31'b0, key_fall},  32'd0);
    tick();
    key_raw = 1'b1;
    rst = 1'b0;
    mark();
    repeat (8) tick();
    chk("async_relatch_rise_edge", rise_edge, 32'd6);

    key_raw = 1'b0;
    repeat (8) tick();

    // Long hold: 12 cycles past the rise, then a further idle hold.
    key_raw = 1'b1;
    mark();
    repeat (18) tick();
`ifdef KEY_LONG_PRESS_EN
    chk("lp_edge", lp_edge, 32'd15);
    chk("lp_cnt", lp_cnt, 32'd1);
`else
    chk("lp_cnt_disabled", lp_cnt, 32'd0);
`endif
    repeat (20) tick();
`ifdef KEY_LONG_PRESS_EN
    chk("lp_no_repeat", lp_cnt, 32'd1);
`else
    chk("lp_no_repeat_disabled", lp_cnt, 32'd0);
`endif
    key_raw = 1'b0;
    repeat (8) tick();

    // Release after 8 high cycles: no long press.
    key_raw = 1'b1;
    mark();
    repeat (8) tick();
    key_raw = 1'b0;
    repeat (10) tick();
    chk("short_hold_fall_edge", fall_edge, 32'd14);
    chk("short_hold_lp_cnt", lp_cnt, 32'd0);

    // Random bouncing with occasional long holds.
    for (int s = 0; s < 250; s++) begin
      val = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(1, 6));
      key_raw = val;
      repeat (len) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
